lsu_ctrl: RTL and testbench

Load/store unit that masters the data-memory port. It is the initiator side of the mem_addr/mem_wdata/mem_rw/mem_rdata bus, and the memory block is the responder.
- Accepts one load or store request at a time from the core's execute stage.
- Performs byte/half/word accesses on a word-only memory (no byte enables). Sub-word stores use read-modify-write.
- Returns load data, sign- or zero-extended, tagged with the destination register index for writeback into rx.

---
 rtl/simprisc_pkg.sv | 28 ++
 rtl/lsu_lane.sv | 48 ++++
 rtl/lsu_ctrl.sv | 158 +++++++++++++++
 tb/tb_lsu_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simprisc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : simprisc_pkg
// Purpose  : Shared types and constants for the load/store unit.
// Revision : 1.0 - initial release
// ============================================================================
package simprisc_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_X = 2'b11
  } lsu_size_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WAIT = 3'd2,
    ST_WR   = 3'd3,
    ST_RESP = 3'd4
  } lsu_state_e;

  localparam int MEM_RD_LAT_MAX = 4;
  localparam int LAT_CNT_W      = $clog2(MEM_RD_LAT_MAX);

endpackage
`default_nettype wire

// File: rtl/lsu_lane.sv
`default_nettype none
// ============================================================================
// Module   : lsu_lane
// Purpose  : Little-endian lane extract/extend for loads and lane merge for
//            sub-word read-modify-write stores.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_lane
  import simprisc_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        sgn,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  lsu_size_e   sz;
  logic [31:0] shifted;

  assign sz      = lsu_size_e'(size);
  assign shifted = rdata >> {lane, 3'b000};

  always_comb begin
    load_data  = rdata;
    merge_data = wdata;
    case (sz)
      SZ_B: begin
        load_data  = {{24{sgn & shifted[7]}}, shifted[7:0]};
        merge_data = rdata;
        merge_data[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_H: begin
        load_data  = {{16{sgn & shifted[15]}}, shifted[15:0]};
        merge_data = rdata;
        merge_data[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: begin
        load_data  = rdata;
        merge_data = wdata;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lsu_ctrl
// Purpose  : Load/store unit mastering a word-only data-memory port; sub-word
//            stores use read-modify-write. Optional macro LSU_ALIGN_CHECK_EN
//            rejects misaligned/illegal-size requests with rsp_err.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_ctrl
  import simprisc_pkg::*;
#(
  parameter int MEM_RD_LAT = 1,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              rsp_valid,
  output logic [31:0]       rsp_data,
  output logic [4:0]        rsp_rd,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_rw,
  input  logic [31:0]       mem_rdata
);

  lsu_state_e           state, state_nx;
  logic [LAT_CNT_W-1:0] cnt;
  logic                 we_q, sgn_q;
  lsu_size_e            size_q;
  logic [1:0]           lane_q;
  logic [31:0]          wdata_q;
  logic [31:0]          load_data, merge_data;

  lsu_size_e            req_sz_eff;
  logic [1:0]           req_lane;
  logic                 req_bad;
  logic                 req_word_store;

  // Request decode: effective size, lane and rejection flag.
  always_comb begin
    req_sz_eff = lsu_size_e'(req_size);
    req_lane   = req_addr[1:0];
    req_bad    = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
    case (lsu_size_e'(req_size))
      SZ_H:    req_bad = req_addr[0];
      SZ_W:    req_bad = |req_addr[1:0];
      SZ_X:    req_bad = 1'b1;
      default: req_bad = 1'b0;
    endcase
`else
    if (req_sz_eff == SZ_X) req_sz_eff = SZ_W;
    case (req_sz_eff)
      SZ_H:    req_lane = {req_addr[1], 1'b0};
      SZ_W:    req_lane = 2'b00;
      default: req_lane = req_addr[1:0];
    endcase
`endif
  end

  assign req_word_store = req_we && (req_sz_eff == SZ_W);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_rw    = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_bad)             state_nx = ST_RESP;
          else if (req_word_store) state_nx = ST_WR;
          else                     state_nx = ST_RD;
        end
      end
      ST_RD:   state_nx = ST_WAIT;
      ST_WAIT: if (cnt == '0) state_nx = we_q ? ST_WR : ST_RESP;
      ST_WR: begin
        mem_rw   = 1'b1;
        state_nx = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        state_nx  = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      we_q      <= 1'b0;
      sgn_q     <= 1'b0;
      size_q    <= SZ_B;
      lane_q    <= 2'b00;
      wdata_q   <= '0;
      rsp_data  <= '0;
      rsp_rd    <= '0;
      rsp_err   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE: if (req_valid) begin
          we_q     <= req_we;
          sgn_q    <= req_signed;
          size_q   <= req_sz_eff;
          lane_q   <= req_lane;
          wdata_q  <= req_wdata;
          rsp_rd   <= req_rd;
          rsp_err  <= req_bad;
          rsp_data <= '0;
          // Rejected requests leave the memory port untouched.
          if (!req_bad) mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
          if (!req_bad && req_word_store) mem_wdata <= req_wdata;
        end
        ST_RD: cnt <= LAT_CNT_W'(MEM_RD_LAT - 1);
        ST_WAIT: begin
          if (cnt == '0) begin
            if (we_q) mem_wdata <= merge_data;
            else      rsp_data  <= load_data;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  lsu_lane u_lane (
    .size       (size_q),
    .lane       (lane_q),
    .sgn        (sgn_q),
    .rdata      (mem_rdata),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_ctrl
// Purpose  : Self-checking bench for lsu_ctrl (read latency 1 and 3 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [1:0]  req_size  [2];
  logic        req_signed[2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [4:0]  req_rd    [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_data  [2];
  logic [4:0]  rsp_rd    [2];
  logic        rsp_err   [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic        mem_rw    [2];
  logic [31:0] mem_rdata [2];

  lsu_ctrl #(.MEM_RD_LAT(1), .ADDR_W(32)) u_dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_size(req_size[0]), .req_signed(req_signed[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .req_rd(req_rd[0]),
    .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]), .rsp_rd(rsp_rd[0]), .rsp_err(rsp_err[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_rw(mem_rw[0]), .mem_rdata(mem_rdata[0])
  );

  lsu_ctrl #(.MEM_RD_LAT(3), .ADDR_W(32)) u_dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_size(req_size[1]), .req_signed(req_signed[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .req_rd(req_rd[1]),
    .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]), .rsp_rd(rsp_rd[1]), .rsp_err(rsp_err[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_rw(mem_rw[1]), .mem_rdata(mem_rdata[1])
  );

  // Responder memories: 256 words each, read data delayed by the instance latency.
  logic [31:0] mem  [2][256];
  logic [31:0] pipe [2][4];
  int          wr_cnt[2];
  int          misalign_cnt[2];
  logic [31:0] wr_addr[2];
  logic        bd_en  [2];
  logic [7:0]  bd_idx [2];
  logic [31:0] bd_data[2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (bd_en[k]) mem[k][bd_idx[k]] <= bd_data[k];
      else if (mem_rw[k] === 1'b1) begin
        mem[k][mem_addr[k][9:2]] <= mem_wdata[k];
        wr_cnt[k]  <= wr_cnt[k] + 1;
        wr_addr[k] <= mem_addr[k];
      end
      if (mem_addr[k][1:0] != 2'b00) misalign_cnt[k] <= misalign_cnt[k] + 1;
      pipe[k][0] <= mem[k][mem_addr[k][9:2]];
      for (int i = 1; i < 4; i++) pipe[k][i] <= pipe[k][i-1];
    end
  end
  assign mem_rdata[0] = pipe[0][0];
  assign mem_rdata[1] = pipe[1][2];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: byte-lane arithmetic straight from the access rules.
  function automatic void ref_model(input int lat, input logic we, input logic [1:0] size,
      input logic sgn, input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] old,
      output logic [31:0] data, output logic err, output int cyc,
      output logic [31:0] nw, output logic [31:0] waddr);
    int nbytes, off, sz;
    logic [31:0] mask, v, a;
    sz = int'(size);
    err = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
    if (sz == 3 || (sz == 1 && addr[0]) || (sz == 2 && addr[1:0] != 2'b00)) err = 1'b1;
`else
    if (sz == 3) sz = 2;
`endif
    if (sz == 3) sz = 2;
    nbytes = 1 << sz;
    a      = addr & ~(32'(nbytes) - 32'd1);
    off    = 8 * int'(a[1:0]);
    mask   = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
    waddr  = a & 32'hFFFF_FFFC;
    nw     = old;
    data   = 32'h0;
    if (err) cyc = 1;
    else if (we) begin
      nw  = (old & ~(mask << off)) | ((wdata & mask) << off);
      cyc = (nbytes == 4) ? 2 : 3 + lat;
    end else begin
      v = (old >> off) & mask;
      if (sgn && nbytes < 4 && v[8*nbytes-1]) v = v | ~mask;
      data = v;
      cyc  = 2 + lat;
    end
  endfunction

  task automatic poke(input int k, input logic [7:0] idx, input logic [31:0] data);
    @(negedge clk);
    bd_en[k] = 1'b1; bd_idx[k] = idx; bd_data[k] = data;
    @(posedge clk); #1;
    bd_en[k] = 1'b0;
  endtask

  task automatic run_txn(input int k, input logic we, input logic [1:0] size, input logic sgn,
      input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
      input logic [31:0] old, input logic [31:0] e_data, input logic e_err, input int e_cyc,
      input logic [31:0] e_new, input logic [31:0] e_waddr, input string tag);
    int n, cyc, w0;
    bit seen, busy_ok;
    poke(k, e_waddr[9:2], old);
    n = 0;
    @(negedge clk);
    while (req_ready[k] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk({tag, "/idle_ready"}, 32'(req_ready[k]), 32'd1);
    w0 = wr_cnt[k];
    req_we[k] = we; req_size[k] = size; req_signed[k] = sgn;
    req_addr[k] = addr; req_wdata[k] = wdata; req_rd[k] = rd;
    req_valid[k] = 1'b1;
    cyc = 0; seen = 0; busy_ok = 1;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid[k] === 1'b1) seen = 1;
      else if (req_ready[k] !== 1'b0) busy_ok = 0;
    end
    req_valid[k] = 1'b0;
    chk({tag, "/rsp_seen"}, 32'(seen), 32'd1);
    chk({tag, "/latency"}, 32'(cyc), 32'(e_cyc));
    chk({tag, "/busy_not_ready"}, 32'(busy_ok), 32'd1);
    chk({tag, "/rsp_data"}, rsp_data[k], e_data);
    chk({tag, "/rsp_rd"}, 32'(rsp_rd[k]), 32'(rd));
    chk({tag, "/rsp_err"}, 32'(rsp_err[k]), 32'(e_err));
    chk({tag, "/ready_in_resp"}, 32'(req_ready[k]), 32'd0);
    @(negedge clk);
    chk({tag, "/pulse_one_cycle"}, 32'(rsp_valid[k]), 32'd0);
    chk({tag, "/ready_after"}, 32'(req_ready[k]), 32'd1);
    chk({tag, "/mem_word"}, mem[k][e_waddr[9:2]], e_new);
    chk({tag, "/write_count"}, 32'(wr_cnt[k] - w0), 32'((we && !e_err) ? 1 : 0));
    if (we && !e_err) chk({tag, "/write_addr"}, wr_addr[k], e_waddr);
    if (!e_err) chk({tag, "/mem_addr"}, mem_addr[k], e_waddr);
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] old;
    logic [31:0] e_data;
    logic        e_err;
    int          e_cyc;
    logic [31:0] e_new;
    logic [31:0] e_waddr;
  } vec_t;

  vec_t tv[12];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, nw, wa;
    logic        e;
    int          c, k;
    logic        r_we, r_sgn;
    logic [1:0]  r_size;
    logic [31:0] r_addr, r_wdata, r_old;
    logic [4:0]  r_rd;

    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 0; req_we[i] = 0; req_size[i] = 0; req_signed[i] = 0;
      req_addr[i] = 0; req_wdata[i] = 0; req_rd[i] = 0;
      bd_en[i] = 0; bd_idx[i] = 0; bd_data[i] = 0;
    end

    // Table: we size sgn addr wdata rd old | data err cyc new waddr (latency-1 instance)
    tv[0]  = '{1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 5'd3, 32'h0,        32'h0,        1'b0, 2, 32'hDEADBEEF, 32'h100};
    tv[1]  = '{1'b1, 2'd0, 1'b0, 32'h101, 32'h0000005A, 5'd4, 32'h11223344, 32'h0,        1'b0, 4, 32'h11225A44, 32'h100};
    tv[2]  = '{1'b0, 2'd0, 1'b1, 32'h103, 32'h0,        5'd7, 32'h80FF0000, 32'hFFFFFF80, 1'b0, 3, 32'h80FF0000, 32'h100};
    tv[3]  = '{1'b0, 2'd0, 1'b0, 32'h103, 32'h0,        5'd7, 32'h80FF0000, 32'h00000080, 1'b0, 3, 32'h80FF0000, 32'h100};
    tv[4]  = '{1'b1, 2'd1, 1'b0, 32'h102, 32'h1234CAFE, 5'd5, 32'h11223344, 32'h0,        1'b0, 4, 32'hCAFE3344, 32'h100};
    tv[5]  = '{1'b0, 2'd1, 1'b1, 32'h100, 32'h0,        5'd6, 32'h12348001, 32'hFFFF8001, 1'b0, 3, 32'h12348001, 32'h100};
    tv[6]  = '{1'b0, 2'd2, 1'b1, 32'h104, 32'h0,        5'd8, 32'hA5A55A5A, 32'hA5A55A5A, 1'b0, 3, 32'hA5A55A5A, 32'h104};
    tv[7]  = '{1'b1, 2'd0, 1'b1, 32'h102, 32'hFFFFFF80, 5'd9, 32'h0,        32'h0,        1'b0, 4, 32'h00800000, 32'h100};
`ifdef LSU_ALIGN_CHECK_EN
    tv[8]  = '{1'b0, 2'd2, 1'b0, 32'h102, 32'h0,        5'd10, 32'hCAFEF00D, 32'h0,       1'b1, 1, 32'hCAFEF00D, 32'h100};
    tv[9]  = '{1'b0, 2'd3, 1'b1, 32'h108, 32'h0,        5'd11, 32'h01020304, 32'h0,       1'b1, 1, 32'h01020304, 32'h108};
    tv[10] = '{1'b0, 2'd1, 1'b0, 32'h201, 32'h0,        5'd12, 32'hBEEF1234, 32'h0,       1'b1, 1, 32'hBEEF1234, 32'h200};
    tv[11] = '{1'b1, 2'd2, 1'b0, 32'h306, 32'hA1B2C3D4, 5'd13, 32'h00000055, 32'h0,       1'b1, 1, 32'h00000055, 32'h304};
`else
    tv[8]  = '{1'b0, 2'd2, 1'b0, 32'h102, 32'h0,        5'd10, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 3, 32'hCAFEF00D, 32'h100};
    tv[9]  = '{1'b0, 2'd3, 1'b1, 32'h108, 32'h0,        5'd11, 32'h01020304, 32'h01020304, 1'b0, 3, 32'h01020304, 32'h108};
    tv[10] = '{1'b0, 2'd1, 1'b0, 32'h201, 32'h0,        5'd12, 32'hBEEF1234, 32'h00001234, 1'b0, 3, 32'hBEEF1234, 32'h200};
    tv[11] = '{1'b1, 2'd2, 1'b0, 32'h306, 32'hA1B2C3D4, 5'd13, 32'h00000055, 32'h0,        1'b0, 2, 32'hA1B2C3D4, 32'h304};
`endif

    reset = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset%0d/req_ready", i), 32'(req_ready[i]), 32'd1);
      chk($sformatf("reset%0d/rsp_valid", i), 32'(rsp_valid[i]), 32'd0);
      chk($sformatf("reset%0d/rsp_data", i), rsp_data[i], 32'd0);
      chk($sformatf("reset%0d/mem_addr", i), mem_addr[i], 32'd0);
      chk($sformatf("reset%0d/mem_rw", i), 32'(mem_rw[i]), 32'd0);
    end
    reset = 1'b0;

    for (int i = 0; i < 12; i++)
      run_txn(0, tv[i].we, tv[i].size, tv[i].sgn, tv[i].addr, tv[i].wdata, tv[i].rd, tv[i].old,
              tv[i].e_data, tv[i].e_err, tv[i].e_cyc, tv[i].e_new, tv[i].e_waddr,
              $sformatf("vec%0d", i));

    // Slow-memory instance: half load and sub-word store.
    run_txn(1, 1'b0, 2'd1, 1'b0, 32'h202, 32'h0, 5'd12, 32'hBEEF1234,
            32'h0000BEEF, 1'b0, 5, 32'hBEEF1234, 32'h200, "lat3_half_load");
    run_txn(1, 1'b1, 2'd0, 1'b0, 32'h203, 32'h00000077, 5'd2, 32'hBEEF1234,
            32'h0, 1'b0, 6, 32'h77EF1234, 32'h200, "lat3_byte_store");

    // Reset while a byte store sits in the read phase.
    poke(0, 8'h10, 32'h11223344);
    @(negedge clk);
    c = wr_cnt[0];
    req_we[0] = 1'b1; req_size[0] = 2'd0; req_signed[0] = 1'b0;
    req_addr[0] = 32'h41; req_wdata[0] = 32'hA5; req_rd[0] = 5'd9; req_valid[0] = 1'b1;
    @(negedge clk);
    chk("midreset/rd_phase_no_write", 32'(mem_rw[0]), 32'd0);
    chk("midreset/rd_phase_addr", mem_addr[0], 32'h40);
    reset = 1'b1; req_valid[0] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset/req_ready", 32'(req_ready[0]), 32'd1);
    chk("midreset/rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("midreset/rsp_data", rsp_data[0], 32'd0);
    chk("midreset/rsp_rd", 32'(rsp_rd[0]), 32'd0);
    chk("midreset/rsp_err", 32'(rsp_err[0]), 32'd0);
    chk("midreset/mem_addr", mem_addr[0], 32'd0);
    chk("midreset/mem_wdata", mem_wdata[0], 32'd0);
    chk("midreset/mem_rw", 32'(mem_rw[0]), 32'd0);
    repeat (6) @(negedge clk);
    chk("midreset/no_write", 32'(wr_cnt[0] - c), 32'd0);
    chk("midreset/mem_word", mem[0][8'h10], 32'h11223344);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 48; i++) begin
      k       = (i % 4 == 3) ? 1 : 0;
      r_we    = 1'($urandom_range(0, 1));
      r_size  = 2'($urandom_range(0, 3));
      r_sgn   = 1'($urandom_range(0, 1));
      r_addr  = 32'($urandom_range(0, 1023));
      r_wdata = $urandom;
      r_rd    = 5'($urandom_range(0, 31));
      r_old   = $urandom;
      ref_model((k == 0) ? 1 : 3, r_we, r_size, r_sgn, r_addr, r_wdata, r_old, d, e, c, nw, wa);
      run_txn(k, r_we, r_size, r_sgn, r_addr, r_wdata, r_rd, r_old, d, e, c, nw, wa,
              $sformatf("rand%0d", i));
    end

    chk("aligned_mem_addr0", 32'(misalign_cnt[0]), 32'd0);
    chk("aligned_mem_addr1", 32'(misalign_cnt[1]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
